// File: rtl/fir_mac_serial_pkg.sv
// Shared definitions for the serial FIR family: FSM encoding and width helpers.
package fir_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_IDLE = 2'd1,
      ST_MAC  = 2'd2,
      ST_OUT  = 2'd3
   } fir_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Wide enough that N_TAPS full-scale products can never overflow.
   function automatic int acc_width(input int bw_in, input int n_taps);
      return 2 * bw_in + clog2(n_taps);
   endfunction

endpackage

// File: rtl/fir_mac_serial_if.sv
// Sample/coefficient input and filtered output bundle for the serial FIR core.
interface fir_mac_serial_if #(
   parameter int BW_IN  = 6,
   parameter int BW_OUT = 8
);
   logic                     coef_load;
   logic                     in_valid;
   logic signed [BW_IN-1:0]  in_data;
   logic                     in_ready;
   logic                     coef_ready;
   logic                     out_valid;
   logic signed [BW_OUT-1:0] out_data;

   modport master (
      output coef_load, in_valid, in_data,
      input  in_ready, coef_ready, out_valid, out_data
   );

   modport slave (
      input  coef_load, in_valid, in_data,
      output in_ready, coef_ready, out_valid, out_data
   );
endinterface

// File: rtl/fir_mac_serial_round_sat.sv
// Round-half-up, arithmetic shift and saturate from accumulator width to BW_OUT.
module fir_round_sat #(
   parameter int ACC_W  = 15,
   parameter int BW_OUT = 8,
   parameter int SHIFT  = 0
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [BW_OUT-1:0] y
);
   localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [ACC_W:0] ONE = {{ACC_W{1'b0}}, 1'b1};
   localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? (ONE << RND_POS) : '0;
   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - BW_OUT){1'b0}}, {(BW_OUT - 1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - BW_OUT){1'b1}}, {(BW_OUT - 1){1'b0}}};

   logic signed [ACC_W:0] ext;
   logic signed [ACC_W:0] shifted;

   // One guard bit so the rounding offset can never wrap the accumulator.
   always_comb begin
      ext     = {acc[ACC_W-1], acc};
      shifted = (ext + RND) >>> SHIFT;
      if (shifted > SAT_MAX) begin
         y = SAT_MAX[BW_OUT-1:0];
      end else if (shifted < SAT_MIN) begin
         y = SAT_MIN[BW_OUT-1:0];
      end else begin
         y = shifted[BW_OUT-1:0];
      end
   end
endmodule

// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one signed multiplier walks N_TAPS taps per sample,
// coefficients are loaded over the sample bus after reset or on request.
module fir_mac_serial
   import fir_pkg::*;
#(
   parameter int N_TAPS = 5,
   parameter int BW_IN  = 6,
   parameter int BW_OUT = 8,
   parameter int SHIFT  = 0
) (
   input  logic             clk,
   input  logic             reset,
   fir_mac_serial_if.slave  bus
);
   localparam int ACC_W = acc_width(BW_IN, N_TAPS);
   localparam int CNT_W = clog2(N_TAPS);
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

   fir_state_t               state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [BW_IN-1:0]  coef_q [N_TAPS];
   logic signed [BW_IN-1:0]  coef_d [N_TAPS];
   logic signed [BW_IN-1:0]  x_q [N_TAPS];
   logic signed [BW_IN-1:0]  x_d [N_TAPS];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [BW_OUT-1:0] out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic                     coef_ready_q, coef_ready_d;
   logic                     in_ready;

   logic signed [2*BW_IN-1:0] prod;
   logic signed [ACC_W-1:0]   mac_sum;
   logic signed [BW_OUT-1:0]  rs_y;

   assign prod    = x_q[cnt_q] * coef_q[cnt_q];
   assign mac_sum = acc_q + ACC_W'(prod);

   // The final product is folded in on the way into OUT so the result is
   // registered in the same cycle out_valid rises.
   fir_round_sat #(
      .ACC_W (ACC_W),
      .BW_OUT(BW_OUT),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .acc(mac_sum),
      .y  (rs_y)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      coef_d       = coef_q;
      x_d          = x_q;
      acc_d        = acc_q;
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      coef_ready_d = coef_ready_q;
      in_ready     = 1'b0;

      case (state_q)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               coef_d[cnt_q] = bus.in_data;
               if (cnt_q == LAST_TAP) begin
                  cnt_d        = '0;
                  coef_ready_d = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_IDLE: begin
            in_ready = !bus.coef_load;
            if (bus.coef_load) begin
               cnt_d        = '0;
               coef_ready_d = 1'b0;
               x_d          = '{default: '0};
               state_d      = ST_LOAD;
            end else if (bus.in_valid) begin
               for (int i = N_TAPS - 1; i > 0; i--) x_d[i] = x_q[i-1];
               x_d[0]  = bus.in_data;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d = mac_sum;
            if (cnt_q == LAST_TAP) begin
               cnt_d       = '0;
               out_data_d  = rs_y;
               out_valid_d = 1'b1;
               state_d     = ST_OUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_OUT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_LOAD;
         cnt_q        <= '0;
         coef_q       <= '{default: '0};
         x_q          <= '{default: '0};
         acc_q        <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         coef_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         coef_q       <= coef_d;
         x_q          <= x_d;
         acc_q        <= acc_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         coef_ready_q <= coef_ready_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.coef_ready = coef_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
endmodule

// File: tb/tb_fir_mac_serial.sv
// Scoreboard bench for fir_mac_serial: one SHIFT=0 and one SHIFT=2 instance,
// directed vectors with hand-computed results, per-instance output monitors.
module tb_fir_mac_serial;
   localparam int N_TAPS  = 5;
   localparam int LATENCY = N_TAPS + 1;

   typedef struct {
      int data;
      int cyc;
   } exp_t;

   logic              clk;
   logic              reset;
   logic              coef_load;
   logic              in_valid;
   logic signed [5:0] in_data;
   int                sel;
   int                cyc;
   int                n_cmp;
   int                n_bad;
   exp_t              q0[$];
   exp_t              q1[$];

   fir_mac_serial_if #(.BW_IN(6), .BW_OUT(8)) bus0 ();
   fir_mac_serial_if #(.BW_IN(6), .BW_OUT(8)) bus2 ();

   assign bus0.coef_load = coef_load & (sel == 0);
   assign bus0.in_valid  = in_valid & (sel == 0);
   assign bus0.in_data   = in_data;
   assign bus2.coef_load = coef_load & (sel == 1);
   assign bus2.in_valid  = in_valid & (sel == 1);
   assign bus2.in_data   = in_data;

   fir_mac_serial #(.N_TAPS(N_TAPS), .BW_IN(6), .BW_OUT(8), .SHIFT(0)) dut0 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus0)
   );

   fir_mac_serial #(.N_TAPS(N_TAPS), .BW_IN(6), .BW_OUT(8), .SHIFT(2)) dut2 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, want $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   function automatic logic readyOf(input int s);
      return (s == 1) ? bus2.in_ready : bus0.in_ready;
   endfunction

   function automatic logic coefReadyOf(input int s);
      return (s == 1) ? bus2.coef_ready : bus0.coef_ready;
   endfunction

   // Presents one word and waits for the handshake; a result expectation is
   // queued against the cycle the word was accepted in.
   task automatic applyStimulus(input int s, input int d, input bit has_out, input int y);
      bit ok;
      ok       = 1'b0;
      sel      = s;
      in_data  = d[5:0];
      in_valid = 1'b1;
      for (int n = 0; n < 64; n++) begin
         if (readyOf(s)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         if (has_out) begin
            if (s == 1) q1.push_back('{y, cyc});
            else        q0.push_back('{y, cyc});
         end
         @(negedge clk);
      end else begin
         checkOutput("accept_timeout", 0, 1);
      end
      in_valid = 1'b0;
   endtask

   task automatic loadCoefs(input int s, input int c[N_TAPS]);
      for (int i = 0; i < N_TAPS; i++) applyStimulus(s, c[i], 1'b0, 0);
   endtask

   task automatic requestReload(input int s);
      bit ok;
      ok        = 1'b0;
      sel       = s;
      coef_load = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!coefReadyOf(s)) begin
            ok = 1'b1;
            break;
         end
      end
      coef_load = 1'b0;
      if (!ok) checkOutput("reload_timeout", 0, 1);
   endtask

   initial begin : monitor0
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus0.out_valid) begin
            if (q0.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("[TB] FAIL out0_unexpected: got %0d, want no output", int'(bus0.out_data));
            end else begin
               e = q0.pop_front();
               checkOutput("out0_data", int'(bus0.out_data), e.data);
               checkOutput("out0_latency", cyc - e.cyc, LATENCY);
            end
         end
      end
   end

   initial begin : monitor2
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus2.out_valid) begin
            if (q1.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("[TB] FAIL out2_unexpected: got %0d, want no output", int'(bus2.out_data));
            end else begin
               e = q1.pop_front();
               checkOutput("out2_data", int'(bus2.out_data), e.data);
               checkOutput("out2_latency", cyc - e.cyc, LATENCY);
            end
         end
      end
   end

   initial begin : stimulus
      int hold_exp[3];
      int pulses;
      int last;
      int seen;

      n_cmp     = 0;
      n_bad     = 0;
      coef_load = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      sel       = 0;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      checkOutput("rst_out_valid", int'(bus0.out_valid), 0);
      checkOutput("rst_out_data", int'(bus0.out_data), 0);
      checkOutput("rst_coef_ready", int'(bus0.coef_ready), 0);
      checkOutput("rst_in_ready", int'(bus0.in_ready), 1);
      checkOutput("rst2_coef_ready", int'(bus2.coef_ready), 0);
      checkOutput("rst2_in_ready", int'(bus2.in_ready), 1);

      // Impulse response reproduces the coefficients in order.
      loadCoefs(0, '{1, 2, 3, 4, 5});
      checkOutput("coef_ready_after_load", int'(bus0.coef_ready), 1);
      applyStimulus(0, 1, 1'b1, 1);
      applyStimulus(0, 0, 1'b1, 2);
      applyStimulus(0, 0, 1'b1, 3);
      applyStimulus(0, 0, 1'b1, 4);
      applyStimulus(0, 0, 1'b1, 5);
      applyStimulus(0, 0, 1'b1, 0);
      repeat (10) @(negedge clk);

      // in_valid held high: running sums of 2*h[k] give 2, 6, 12.
      hold_exp = '{2, 6, 12};
      pulses   = 0;
      last     = -1;
      sel      = 0;
      in_data  = 6'sd2;
      in_valid = 1'b1;
      for (int n = 0; n < 21; n++) begin
         if (bus0.in_ready) begin
            if (pulses < 3) q0.push_back('{hold_exp[pulses], cyc});
            if (last >= 0) checkOutput("ready_spacing", cyc - last, N_TAPS + 2);
            last = cyc;
            pulses++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checkOutput("ready_pulses", pulses, 3);
      repeat (12) @(negedge clk);

      requestReload(0);
      loadCoefs(0, '{31, 31, 31, 31, 31});
      repeat (5) applyStimulus(0, 31, 1'b1, 127);
      repeat (10) @(negedge clk);
      requestReload(0);
      loadCoefs(0, '{-32, -32, -32, -32, -32});
      repeat (5) applyStimulus(0, 31, 1'b1, -128);
      repeat (10) @(negedge clk);

      // coef_load beats a simultaneous sample in IDLE.
      sel       = 0;
      coef_load = 1'b1;
      in_valid  = 1'b1;
      in_data   = 6'sd7;
      #1;
      checkOutput("collide_in_ready", int'(bus0.in_ready), 0);
      @(negedge clk);
      coef_load = 1'b0;
      in_valid  = 1'b0;
      checkOutput("collide_coef_ready", int'(bus0.coef_ready), 0);
      checkOutput("collide_in_load", int'(bus0.in_ready), 1);
      loadCoefs(0, '{5, 4, 3, 2, 1});
      applyStimulus(0, 1, 1'b1, 5);
      applyStimulus(0, 0, 1'b1, 4);
      applyStimulus(0, 0, 1'b1, 3);
      applyStimulus(0, 0, 1'b1, 2);
      applyStimulus(0, 0, 1'b1, 1);
      repeat (10) @(negedge clk);

      // Reset lands on the third MAC cycle of an accepted sample.
      applyStimulus(0, 9, 1'b0, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midrst_out_data", int'(bus0.out_data), 0);
      checkOutput("midrst_coef_ready", int'(bus0.coef_ready), 0);
      checkOutput("midrst_in_ready", int'(bus0.in_ready), 1);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus0.out_valid) seen++;
      end
      checkOutput("midrst_no_valid", seen, 0);
      loadCoefs(0, '{3, 0, 0, 0, 0});
      applyStimulus(0, 2, 1'b1, 6);
      repeat (10) @(negedge clk);

      // SHIFT=2 instance: round-half-up then arithmetic shift.
      loadCoefs(1, '{1, 0, 0, 0, 0});
      applyStimulus(1, 6, 1'b1, 2);
      applyStimulus(1, -6, 1'b1, -1);
      applyStimulus(1, 5, 1'b1, 1);
      applyStimulus(1, -7, 1'b1, -2);
      applyStimulus(1, -2, 1'b1, 0);
      repeat (12) @(negedge clk);

      checkOutput("q0_drained", q0.size(), 0);
      checkOutput("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
